fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  CPU instruction-fetch stage, directly upstream of control_unit. Owns the PC, drives the synchronous
//  instruction memory and presents the fetched word (opcode/x_bit) to decode/control. Consumes
//  control_unit's STALL_control, halt, branch, jump and jump_immd. Resolves branch conditions from the
//  Z/N/V flags and redirects the PC with a one-bubble squash.
// PARAMETERS
//  PC_W      16            PC / instruction-memory address width
//  INSTR_W   32            instruction width; opcode = [INSTR_W-1 -: 5], x_bit = [INSTR_W-6]
//  OFF_W     11            signed branch offset width
//  RESET_PC  0             first fetch address after reset
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        synchronous, active-low reset
//  stall        in   1        STALL_control; freeze fetch and decode regs
//  halt         in   1        HALT decoded; latch halted state
//  branch       in   1        B instruction in decode
//  br_cond      in   3        branch condition field of decoded instr
//  br_off       in   OFF_W    signed offset, relative to decoded pc+1
//  flag_z/n/v   in   1 each   current Z, N, V flags
//  jump         in   1        J instruction in decode
//  jump_immd    in   1        1: target = jump_imm, 0: target = jump_reg
//  jump_imm     in   PC_W     immediate jump target
//  jump_reg     in   PC_W     register (Rt) jump target
//  imem_addr    out  PC_W     instruction-memory address
//  imem_rd_en   out  1        memory read enable; when low, memory holds rdata
//  imem_rdata   in   INSTR_W  memory data, 1-cycle read latency
//  instr_out    out  INSTR_W  instruction in decode
//  instr_valid  out  1        instr_out is real (not bubble)
//  pc_out       out  PC_W     PC of instr_out
//  pc_plus1     out  PC_W     pc_out+1 (return address for pcr_to_reg)
//  redirect     out  1        taken branch/jump this cycle (combinational)
//  halted       out  1        fetch permanently stopped
// BEHAVIOUR
//  - Reset (clk edge with rst_n=0): fetch_pc=RESET_PC; instr_out=NOP_INSTR; instr_valid=0; pc_out=0;
//    halted=0; squash=0. While in reset, imem_addr=RESET_PC, imem_rd_en=1.
//  - Pipeline: address A on imem_addr in cycle n -> word appears on imem_rdata in n+1 ->
//    instr_out/pc_out registered at end of n+1. Fetch-to-decode latency = 2 cycles. Then 1 instr/cycle.
//  - Normal (no stall, no redirect): fetch_pc <= fetch_pc+1. instr_out <= imem_rdata,
//    pc_out <= address issued the previous cycle, and instr_valid <= ~squash.
//  - Stall=1: fetch_pc, instr_out, pc_out, instr_valid and squash hold; imem_rd_en=0, so rdata holds.
//    The pending word is consumed on the first cycle after stall drops. No redirect is taken while stall=1.
//  - Branch taken iff branch & instr_valid & ~stall & cond_true:
//    000 EQ Z | 001 NE ~Z | 010 GT ~Z&~N | 011 LT N | 100 GE ~N | 101 LE Z|N | 110 OV V | 111 always.
//    Target = pc_out + 1 + sext(br_off). Arithmetic is mod 2^PC_W; wrap-around is legal.
//  - Jump taken iff jump & instr_valid & ~stall. Target = jump_immd ? jump_imm : jump_reg.
//    jump and branch are never both asserted. If both are, jump wins.
//  - Redirect cycle: imem_addr = target (combinational bypass); fetch_pc <= target+1; squash <= 1.
//    The word returning next cycle (fetched from old pc+1) is loaded with instr_valid=0: one bubble.
//  - A redirect arriving while squash=1 is impossible, because instr_valid=0 gates it.
//  - halt & instr_valid & ~stall_except_halt: halted <= 1 (sticky until rst_n).
//    The gating ignores halt's own contribution to stall.
//  - While halted: imem_rd_en=0, instr_valid=0, and fetch_pc/pc_out freeze.
//  - Priority per edge: rst_n > halted > stall > redirect > sequential increment.
//  - Reset mid-operation: all state returns to reset values in one edge. No partial squash survives.
//  - redirect output = taken branch | taken jump, for debug and hazard logic.
// STRUCTURE
//  - cpu_pkg: opcode localparams (AND..HALT), branch-condition codes BR_EQ..BR_AL, NOP_INSTR
//    (opcode 5'b01111, wait 0), PC_W/INSTR_W defaults.
//  - Sub-module branch_cond_eval: combinational (br_cond, Z, N, V) -> cond_true, so it can be unit-tested.
//  - Top holds fetch_pc, squash, halted, decode regs and next-PC mux.
// TESTING
//  1 Reset then run 4 cycles, imem[k]=k+0x100 -> imem_addr 0,1,2,3. instr_out 0x100 valid at cycle 2,
//    pc_out=0, pc_plus1=1.
//  2 Stall held 3 cycles while instr at pc 5 is in decode -> instr_out/pc_out constant, imem_rd_en=0.
//    Release -> pc 6 appears the next cycle with no lost or duplicated instr.
//  3 BEQ at pc 0x10, off=-4, Z=1 -> imem_addr=0x0D that cycle. Next instr_valid=0 (bubble).
//    Then pc_out=0x0D. With Z=0 -> no redirect, pc 0x11 follows.
//  4 J jump_immd=0, jump_reg=0x0040 at pc 0x20 -> pc_plus1=0x21; next valid pc_out=0x40 after one bubble.
//  5 Branch at pc 0xFFFE, off=+3, cond 111 -> target wraps to 0x0002.
//  6 HALT in decode -> halted=1 next edge, instr_valid stays 0, imem_rd_en=0.
//    rst_n low 1 cycle -> refetch from RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Package : cpu_pkg                                                        |
// | Shared CPU constants: opcodes, branch-condition codes, NOP encoding and    |
// | default datapath widths.                                                  |
// | Revision: 1.0 - initial release                                           |
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int PC_W_DEF    = 16;
  localparam int INSTR_W_DEF = 32;
  localparam int OFF_W_DEF   = 11;

  // 5-bit major opcodes
  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00011;
  localparam logic [4:0] OP_LD   = 5'b01000;
  localparam logic [4:0] OP_ST   = 5'b01001;
  localparam logic [4:0] OP_B    = 5'b01010;
  localparam logic [4:0] OP_J    = 5'b01011;
  localparam logic [4:0] OP_NOP  = 5'b01111;
  localparam logic [4:0] OP_HALT = 5'b11111;

  // Wait field zero: a plain no-op occupying the decode slot
  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = {OP_NOP, {(INSTR_W_DEF-5){1'b0}}};

  typedef enum logic [2:0] {
    BR_EQ = 3'b000,
    BR_NE = 3'b001,
    BR_GT = 3'b010,
    BR_LT = 3'b011,
    BR_GE = 3'b100,
    BR_LE = 3'b101,
    BR_OV = 3'b110,
    BR_AL = 3'b111
  } br_cond_e;

endpackage
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module  : branch_cond_eval                                               |
// | Combinational branch-condition resolver: (cond, Z, N, V) -> taken.        |
// | Revision: 1.0 - initial release                                           |
// ---------------------------------------------------------------------------
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] i_br_cond,
  input  logic       i_flag_z,
  input  logic       i_flag_n,
  input  logic       i_flag_v,
  output logic       o_cond_true
);

  // Decode the condition field against the current flags
  always_comb begin
    o_cond_true = 1'b0;
    case (br_cond_e'(i_br_cond))
      BR_EQ:   o_cond_true = i_flag_z;
      BR_NE:   o_cond_true = ~i_flag_z;
      BR_GT:   o_cond_true = ~i_flag_z & ~i_flag_n;
      BR_LT:   o_cond_true = i_flag_n;
      BR_GE:   o_cond_true = ~i_flag_n;
      BR_LE:   o_cond_true = i_flag_z | i_flag_n;
      BR_OV:   o_cond_true = i_flag_v;
      BR_AL:   o_cond_true = 1'b1;
      default: o_cond_true = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module  : fetch_unit                                                     |
// | Instruction-fetch stage: owns the PC, drives the synchronous instruction  |
// | memory, presents fetched words to decode and resolves branches/jumps      |
// | with a single-bubble squash.                                              |
// | Revision: 1.0 - initial release                                           |
// ---------------------------------------------------------------------------
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter int              OFF_W    = OFF_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               halt,
  input  logic               branch,
  input  logic [2:0]         br_cond,
  input  logic [OFF_W-1:0]   br_off,
  input  logic               flag_z,
  input  logic               flag_n,
  input  logic               flag_v,
  input  logic               jump,
  input  logic               jump_immd,
  input  logic [PC_W-1:0]    jump_imm,
  input  logic [PC_W-1:0]    jump_reg,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_rd_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc_out,
  output logic [PC_W-1:0]    pc_plus1,
  output logic               redirect,
  output logic               halted
);

  localparam logic [INSTR_W-1:0] c_nop_instr = {OP_NOP, {(INSTR_W-5){1'b0}}};

  logic [PC_W-1:0]    r_fetch_pc;   // next sequential fetch address
  logic [PC_W-1:0]    r_issued_pc;  // address whose word is on imem_rdata now
  logic               r_rdata_ok;   // imem_rdata belongs to a post-reset fetch
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;
  logic               r_halted;

  logic               w_cond_true;
  logic               w_can_redirect;
  logic               w_jmp_taken;
  logic               w_br_taken;
  logic               w_redirect;
  logic               w_halt_take;
  logic [PC_W-1:0]    w_br_target;
  logic [PC_W-1:0]    w_jmp_target;
  logic [PC_W-1:0]    w_target;

  branch_cond_eval u_cond (
    .i_br_cond   (br_cond),
    .i_flag_z    (flag_z),
    .i_flag_n    (flag_n),
    .i_flag_v    (flag_v),
    .o_cond_true (w_cond_true)
  );

  // Redirect resolution and next-address mux (target bypasses straight to memory)
  always_comb begin
    w_br_target    = r_pc + PC_W'(1) + {{(PC_W-OFF_W){br_off[OFF_W-1]}}, br_off};
    w_jmp_target   = jump_immd ? jump_imm : jump_reg;
    w_can_redirect = rst_n & r_valid & ~stall & ~r_halted;
    w_jmp_taken    = jump & w_can_redirect;
    w_br_taken     = branch & w_cond_true & w_can_redirect & ~jump;
    w_redirect     = w_jmp_taken | w_br_taken;
    w_target       = w_jmp_taken ? w_jmp_target : w_br_target;
    // Halt's own stall contribution is ignored, so stall does not gate it
    w_halt_take    = halt & r_valid & ~r_halted;
    if (!rst_n) begin
      imem_addr = RESET_PC;
    end else if (w_redirect) begin
      imem_addr = w_target;
    end else begin
      imem_addr = r_fetch_pc;
    end
    imem_rd_en = ~rst_n | (~r_halted & ~stall);
  end

  // PC, decode registers and halt state; priority reset > halted > stall > advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc  <= RESET_PC;
      r_issued_pc <= RESET_PC;
      r_rdata_ok  <= 1'b0;
      r_pc        <= '0;
      r_instr     <= c_nop_instr;
      r_valid     <= 1'b0;
      r_halted    <= 1'b0;
    end else if (r_halted) begin
      r_valid <= 1'b0;
    end else if (w_halt_take) begin
      r_halted <= 1'b1;
      r_valid  <= 1'b0;
    end else if (!stall) begin
      // imem_addr already carries the redirect target when one is taken
      r_fetch_pc  <= imem_addr + PC_W'(1);
      r_issued_pc <= imem_addr;
      r_rdata_ok  <= 1'b1;
      r_instr     <= imem_rdata;
      r_pc        <= r_issued_pc;
      // Word returning during a redirect is the wrong-path one: load it as a bubble
      r_valid     <= r_rdata_ok & ~w_redirect;
    end
  end

  always_comb begin
    instr_out   = r_instr;
    instr_valid = r_valid;
    pc_out      = r_pc;
    pc_plus1    = r_pc + PC_W'(1);
    redirect    = w_redirect;
    halted      = r_halted;
  end

endmodule
`default_nettype wire
